serial_frame_tx: RTL and testbench
==================================

// Module: serial_frame_tx
// PURPOSE
//  Framed serial bit-stream transmitter. Accepts a parallel word on a
//  valid/ready handshake and drives it onto a 1-bit line sdo as a frame:
//  start bit, DATA_W data bits, stop bit. sdo changes only on posedge clk.
//  It feeds the posedge-sampling D-flop receivers in the same design.
// PARAMETERS
//  DATA_W        8  data bits per frame (>=1)
//  CLKS_PER_BIT  1  clk cycles each bit is held on sdo (>=1)
//  MSB_FIRST     1  1: din[DATA_W-1] sent first; 0: din[0] sent first
// PORTS
//  clk         in   1       system clock, all state updates on posedge
//  rst_n       in   1       asynchronous active-low reset
//  din         in   DATA_W  word to transmit, sampled on accept
//  din_valid   in   1       source has a word on din
//  din_ready   out  1       block can accept; accept = din_valid & din_ready
//  sdo         out  1       serial line, registered
//  busy        out  1       frame in progress (START, DATA or STOP)
//  frame_done  out  1       1-cycle pulse, registered, on last STOP cycle
// BEHAVIOUR
//  Line levels: idle 0, start bit 1, stop bit 0.
//  Reset (rst_n=0, async): state IDLE, sdo=0, busy=0, frame_done=0,
//   din_ready=1 once rst_n is high, shift reg and counters cleared.
//  FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE:  din_ready=1. On accept at edge N: latch din, go START;
//          sdo=1 and busy=1 from edge N onward (latency 1 edge).
//   START: hold sdo=1 for CLKS_PER_BIT cycles, then DATA.
//   DATA:  each bit held CLKS_PER_BIT cycles, order per MSB_FIRST;
//          bit index counts 0..DATA_W-1, after last bit go STOP.
//   STOP:  sdo=0 for CLKS_PER_BIT cycles; frame_done=1 during the final
//          STOP cycle; then IDLE with din_ready=1 on the next cycle.
//  Frame length = (DATA_W+2)*CLKS_PER_BIT cycles; min gap between
//   accepts = frame length + 1 cycle (one IDLE cycle is mandatory).
//  din_ready=0 in all non-IDLE states; din_valid while busy is ignored,
//   the source holds its word (no loss, no overwrite of the shift reg).
//  din changes after accept have no effect on the current frame.
//  Bit-period counter: width $clog2(CLKS_PER_BIT)+1, wraps to 0 at
//   CLKS_PER_BIT-1; CLKS_PER_BIT=1 gives one bit per cycle, no stalls.
//  Reset asserted mid-frame: frame aborted immediately, sdo=0, no
//   frame_done pulse; the next accept starts a fresh frame.
//  No X on any output after reset regardless of din/din_valid values.
// STRUCTURE
//  Package serial_frame_pkg: state enum (S_IDLE,S_START,S_DATA,S_STOP),
//   constants LINE_IDLE=1'b0, LINE_START=1'b1, LINE_STOP=1'b0.
//  One sub-module: bit_timer (CLKS_PER_BIT down/up counter with
//   clear and 1-cycle 'tick' at end of each bit period).
//  Top holds FSM, shift register, bit index, output registers.
// TESTING
//  1 DATA_W=8,CPB=1,MSB_FIRST=1: accept 8'hA5 -> sdo 1,1,0,1,0,0,1,0,1,0
//    on 10 consecutive cycles; frame_done on cycle 10; ready back cycle 11.
//  2 Same, MSB_FIRST=0, 8'h01 -> sdo 1,1,0,0,0,0,0,0,0,0; sample sdo with
//    the posedge D-flop and compare captured bits to expected.
//  3 CPB=3, 8'hF0 -> each level held exactly 3 cycles, total 30 cycles,
//    busy high for all 30, frame_done single pulse.
//  4 din_valid held high with 8'h3C then 8'hC3 back-to-back -> two full
//    frames, one IDLE cycle between, 2nd word unaffected by 1st.
//  5 rst_n low at cycle 5 of an 8'hFF frame -> sdo=0, busy=0 at once, no
//    frame_done; new accept of 8'h81 after release sends a clean frame.
//  6 Change din during a frame (8'h55 accepted, din->8'hAA) -> 8'h55 sent.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// ============================================================================
//  Module   : serial_frame_pkg
//  Brief    : Shared state encoding and line levels for the framed serial TX.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package serial_frame_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam logic LINE_IDLE  = 1'b0;
    localparam logic LINE_START = 1'b1;
    localparam logic LINE_STOP  = 1'b0;

endpackage

`default_nettype wire

// File: rtl/serial_frame_tx_bit_timer.sv
// ============================================================================
//  Module   : bit_timer
//  Brief    : Bit-period counter; 'tick' marks the last cycle of each period.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick,
    output logic tick_next
);

    localparam int              CW     = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0]   c_last = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    always_comb begin
        tick = en && (r_cnt == c_last);
        if (clr || tick) begin
            w_cnt_next = '0;
        end else if (en) begin
            w_cnt_next = r_cnt + CW'(1);
        end else begin
            w_cnt_next = r_cnt;
        end
        // Lets the owner register a pulse that lines up with the next tick.
        tick_next = (w_cnt_next == c_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/serial_frame_tx.sv
// ============================================================================
//  Module   : serial_frame_tx
//  Brief    : Framed serial transmitter: start bit, DATA_W data bits, stop bit.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int MSB_FIRST    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sdo,
    output logic              busy,
    output logic              frame_done
);

    localparam int            IW         = $clog2(DATA_W) + 1;
    localparam logic [IW-1:0] c_last_idx = IW'(DATA_W - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_next;
    logic [DATA_W-1:0] w_shifted;
    logic [IW-1:0]     r_bit_idx;
    logic [IW-1:0]     w_bit_idx_next;
    logic              r_sdo;
    logic              r_busy;
    logic              r_frame_done;
    logic              w_sdo_next;
    logic              w_head;
    logic              w_accept;
    logic              w_tick;
    logic              w_tick_next;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (r_state == S_IDLE),
        .en        (r_state != S_IDLE),
        .tick      (w_tick),
        .tick_next (w_tick_next)
    );

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        w_accept       = din_valid && (r_state == S_IDLE);
        w_shifted      = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next   = S_START;
                    w_shift_next   = din;
                    w_bit_idx_next = '0;
                end
            end
            S_START: begin
                if (w_tick) w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == c_last_idx) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_shift_next   = w_shifted;
                        w_bit_idx_next = r_bit_idx + IW'(1);
                    end
                end
            end
            S_STOP: begin
                if (w_tick) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase

        // The bit currently on the wire always sits at the head of the shift reg.
        w_head = (MSB_FIRST != 0) ? w_shift_next[DATA_W-1] : w_shift_next[0];

        case (w_state_next)
            S_START: w_sdo_next = LINE_START;
            S_DATA:  w_sdo_next = w_head;
            S_STOP:  w_sdo_next = LINE_STOP;
            default: w_sdo_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_sdo        <= LINE_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_shift      <= w_shift_next;
            r_bit_idx    <= w_bit_idx_next;
            r_sdo        <= w_sdo_next;
            r_busy       <= (w_state_next != S_IDLE);
            r_frame_done <= (w_state_next == S_STOP) && w_tick_next;
        end
    end

    assign din_ready  = (r_state == S_IDLE);
    assign sdo        = r_sdo;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
// ============================================================================
//  Module   : tb_serial_frame_tx
//  Brief    : Scoreboard bench for serial_frame_tx across three configurations.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din [3];
    logic [2:0] vld;
    logic [2:0] rdy;
    logic [2:0] sdo;
    logic [2:0] busy;
    logic [2:0] done;
    logic       cap1;

    int total = 0;
    int bad   = 0;

    // Per-cycle expectation {din_ready, busy, sdo, frame_done}
    logic [3:0] exp_q [$];

    always #5 clk = ~clk;

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .din(din[0]), .din_valid(vld[0]),
        .din_ready(rdy[0]), .sdo(sdo[0]), .busy(busy[0]), .frame_done(done[0])
    );

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .din(din[1]), .din_valid(vld[1]),
        .din_ready(rdy[1]), .sdo(sdo[1]), .busy(busy[1]), .frame_done(done[1])
    );

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(3), .MSB_FIRST(1)) u_slow (
        .clk(clk), .rst_n(rst_n), .din(din[2]), .din_valid(vld[2]),
        .din_ready(rdy[2]), .sdo(sdo[2]), .busy(busy[2]), .frame_done(done[2])
    );

    // Downstream posedge receiver flop on the LSB-first line
    always_ff @(posedge clk) cap1 <= sdo[1];

    function automatic logic [3:0] obs(input int s);
        return {rdy[s], busy[s], sdo[s], done[s]};
    endfunction

    task automatic push_frame(input logic [7:0] w, input int cpb, input bit msb);
        logic b;
        for (int k = 0; k < cpb; k++) exp_q.push_back(4'b0110);
        for (int i = 0; i < 8; i++) begin
            b = msb ? w[7-i] : w[i];
            for (int k = 0; k < cpb; k++) exp_q.push_back({1'b0, 1'b1, b, 1'b0});
        end
        for (int k = 0; k < cpb; k++) exp_q.push_back({1'b0, 1'b1, 1'b0, (k == cpb - 1)});
        exp_q.push_back(4'b1000);
    endtask

    task automatic send(input int s, input logic [7:0] w);
        @(negedge clk);
        din[s] = w;
        vld[s] = 1'b1;
        @(negedge clk);
        vld[s] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            total++;
            if ({busy[s], sdo[s], done[s]} !== 3'b000) begin
                bad++;
                $display("FAIL reset_outputs inst%0d: got busy/sdo/done=%b want 000", s, {busy[s], sdo[s], done[s]});
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            total++;
            if (rdy[s] !== 1'b1) begin
                bad++;
                $display("FAIL reset_ready inst%0d: got %b want 1", s, rdy[s]);
            end
        end
    endtask

    task automatic test_msb_first();
        logic [3:0] e;
        int n = 0;
        send(0, 8'hA5);
        push_frame(8'hA5, 1, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs(0) !== e) begin
                bad++;
                $display("FAIL msb_first cycle %0d: got rdy/busy/sdo/done=%b want %b", n + 1, obs(0), e);
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_lsb_first();
        logic [3:0] e;
        logic       prev = 1'b0;
        int n = 0;
        send(1, 8'h01);
        push_frame(8'h01, 1, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs(1) !== e) begin
                bad++;
                $display("FAIL lsb_first cycle %0d: got rdy/busy/sdo/done=%b want %b", n + 1, obs(1), e);
            end
            if (n > 0) begin
                total++;
                if (cap1 !== prev) begin
                    bad++;
                    $display("FAIL lsb_capture cycle %0d: got %b want %b", n, cap1, prev);
                end
            end
            prev = e[1];
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_slow_bits();
        logic [3:0] e;
        int n = 0;
        int pulses = 0;
        int busy_cycles = 0;
        send(2, 8'hF0);
        push_frame(8'hF0, 3, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs(2) !== e) begin
                bad++;
                $display("FAIL slow_bits cycle %0d: got rdy/busy/sdo/done=%b want %b", n + 1, obs(2), e);
            end
            if (done[2] === 1'b1) pulses++;
            if (busy[2] === 1'b1) busy_cycles++;
            n++;
            @(negedge clk);
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL slow_done_count: got %0d want 1", pulses);
        end
        total++;
        if (busy_cycles != 30) begin
            bad++;
            $display("FAIL slow_busy_cycles: got %0d want 30", busy_cycles);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        int n = 0;
        @(negedge clk);
        din[0] = 8'h3C;
        vld[0] = 1'b1;
        @(negedge clk);
        push_frame(8'h3C, 1, 1'b1);
        push_frame(8'hC3, 1, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs(0) !== e) begin
                bad++;
                $display("FAIL back_to_back cycle %0d: got rdy/busy/sdo/done=%b want %b", n + 1, obs(0), e);
            end
            if (n == 0)  din[0] = 8'hC3;
            if (n == 11) vld[0] = 1'b0;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] e;
        send(0, 8'hFF);
        push_frame(8'hFF, 1, 1'b1);
        for (int n = 0; n < 5; n++) begin
            if (n > 0) @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (obs(0) !== e) begin
                bad++;
                $display("FAIL abort_pre cycle %0d: got rdy/busy/sdo/done=%b want %b", n + 1, obs(0), e);
            end
        end
        exp_q.delete();
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({busy[0], sdo[0], done[0]} !== 3'b000) begin
            bad++;
            $display("FAIL abort_immediate: got busy/sdo/done=%b want 000", {busy[0], sdo[0], done[0]});
        end
        @(negedge clk);
        total++;
        if ({busy[0], sdo[0], done[0]} !== 3'b000) begin
            bad++;
            $display("FAIL abort_held: got busy/sdo/done=%b want 000", {busy[0], sdo[0], done[0]});
        end
        rst_n = 1'b1;
        test_msb_after_abort();
    endtask

    task automatic test_msb_after_abort();
        logic [3:0] e;
        int n = 0;
        send(0, 8'h81);
        push_frame(8'h81, 1, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs(0) !== e) begin
                bad++;
                $display("FAIL after_abort cycle %0d: got rdy/busy/sdo/done=%b want %b", n + 1, obs(0), e);
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_din_change();
        logic [3:0] e;
        int n = 0;
        send(0, 8'h55);
        din[0] = 8'hAA;
        push_frame(8'h55, 1, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs(0) !== e) begin
                bad++;
                $display("FAIL din_change cycle %0d: got rdy/busy/sdo/done=%b want %b", n + 1, obs(0), e);
            end
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        vld = 3'b000;
        for (int s = 0; s < 3; s++) din[s] = 8'h00;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_slow_bits();
        test_back_to_back();
        test_reset_mid_frame();
        test_din_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

`default_nettype wire
